// File: rtl/fft_peak_pkg.sv
// Shared types and constants for the FFT spectral peak detector.
package fft_peak_pkg;

   localparam int DEF_IN_W    = 32;
   localparam int DEF_TRUNC_W = 16;
   localparam int DEF_PTS_W   = 11;
   localparam int POW_W       = 2 * DEF_TRUNC_W + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_t;

   // Per-beat tags that travel beside the data; bin is sized for the default frame width.
   typedef struct packed {
      logic                 sop;
      logic                 report;
      logic                 kill;
      logic                 in_range;
      logic [DEF_PTS_W-1:0] bin;
   } tag_t;

endpackage

// File: rtl/fft_power_calc.sv
// Truncates each complex sample and forms re^2 + im^2, carrying the beat tags alongside.
module fft_power_calc
   import fft_peak_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int TRUNC_W = DEF_TRUNC_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [IN_W-1:0]     re,
   input  logic [IN_W-1:0]     im,
   input  tag_t                tag_in,
   output logic [2*TRUNC_W:0]  pow,
   output tag_t                tag_out
);

   logic signed [TRUNC_W-1:0]   t_re;
   logic signed [TRUNC_W-1:0]   t_im;
   logic signed [2*TRUNC_W-1:0] sq_re;
   logic signed [2*TRUNC_W-1:0] sq_im;
   tag_t                        tag_s1;
   tag_t                        tag_s2;

   // Fractional bits below the kept MSBs are discarded by design.
   logic unused_low;
   assign unused_low = ^{re[IN_W-TRUNC_W-1:0], im[IN_W-TRUNC_W-1:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_re   <= '0;
         t_im   <= '0;
         tag_s1 <= '0;
         sq_re  <= '0;
         sq_im  <= '0;
         tag_s2 <= '0;
      end else begin
         t_re   <= re[IN_W-1 -: TRUNC_W];
         t_im   <= im[IN_W-1 -: TRUNC_W];
         tag_s1 <= tag_in;
         sq_re  <= t_re * t_re;
         sq_im  <= t_im * t_im;
         tag_s2 <= tag_s1;
      end
   end

   // Squares are non-negative, so zero-extending them gives an exact unsigned sum.
   assign pow     = {1'b0, sq_re} + {1'b0, sq_im};
   assign tag_out = tag_s2;

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming peak-bin finder on FFT output frames; reports strongest positive-frequency bin.
// Define FFT_PEAK_DC_SKIP_EN to exclude bins below MIN_BIN from the search.
module fft_peak_detect
   import fft_peak_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int TRUNC_W = DEF_TRUNC_W,
   parameter int PTS_W   = DEF_PTS_W,
   parameter int MIN_BIN = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                src_valid,
   input  logic                src_sop,
   input  logic                src_eop,
   input  logic [IN_W-1:0]     src_real,
   input  logic [IN_W-1:0]     src_imag,
   input  logic [PTS_W-1:0]    fft_pts,
   output logic                peak_valid,
   output logic [PTS_W-1:0]    peak_bin,
   output logic [2*TRUNC_W:0]  peak_power,
   output logic                frame_err
);

`ifdef FFT_PEAK_DC_SKIP_EN
   localparam bit DC_SKIP = 1'b1;
`else
   localparam bit DC_SKIP = 1'b0;
`endif
   localparam logic [PTS_W-1:0] LO = DC_SKIP ? PTS_W'(MIN_BIN) : '0;

   state_t             state;
   logic [PTS_W-1:0]   pts_q;
   logic [PTS_W-1:0]   bin_q;

   logic               in_frame;
   logic [PTS_W-1:0]   cur_pts;
   logic [PTS_W-1:0]   cur_bin;
   logic [PTS_W-1:0]   half;
   logic [PTS_W-1:0]   hi;
   logic               last;
   logic               rpt;
   logic               kill;
   logic               err;
   logic               in_range;
   tag_t               tag_in;
   tag_t               tag_s2;
   logic [2*TRUNC_W:0] pow;

   logic [PTS_W-1:0]   max_bin;
   logic [2*TRUNC_W:0] max_pow;
   logic [PTS_W-1:0]   base_bin;
   logic [2*TRUNC_W:0] base_pow;
   logic [PTS_W-1:0]   best_bin;
   logic [2*TRUNC_W:0] best_pow;
   logic               take;

   // A sop beat always opens a frame at bin 0, even if one is already in flight.
   always_comb begin
      in_frame = src_valid & (src_sop | (state == FRAME));
      cur_pts  = src_sop ? fft_pts : pts_q;
      cur_bin  = src_sop ? '0 : bin_q;
      half     = cur_pts >> 1;
      hi       = (half == '0) ? '0 : half - PTS_W'(1);
      last     = (cur_bin == cur_pts - PTS_W'(1));
      rpt      = in_frame & src_eop & last;
      kill     = in_frame & (src_eop ^ last);
      err      = kill | (src_valid & (((state == FRAME) & src_sop) |
                                      ((state == IDLE) & ~src_sop & src_eop)));
      in_range = ($signed({1'b0, cur_bin}) >= $signed({1'b0, LO})) && (cur_bin <= hi);
      tag_in   = '0;
      if (in_frame) begin
         tag_in.sop      = src_sop;
         tag_in.report   = rpt;
         tag_in.kill     = kill;
         tag_in.in_range = in_range;
         tag_in.bin      = DEF_PTS_W'(cur_bin);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pts_q     <= '0;
         bin_q     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err;
         if (in_frame) begin
            if (src_sop)
               pts_q <= fft_pts;
            bin_q <= cur_bin + PTS_W'(1);
            state <= (rpt | kill) ? IDLE : FRAME;
         end
      end
   end

   fft_power_calc #(
      .IN_W    (IN_W),
      .TRUNC_W (TRUNC_W)
   ) u_power (
      .clk     (clk),
      .reset_n (reset_n),
      .re      (src_real),
      .im      (src_imag),
      .tag_in  (tag_in),
      .pow     (pow),
      .tag_out (tag_s2)
   );

   // Strictly-greater update keeps the lowest bin on ties; sop restarts from (lo, 0).
   always_comb begin
      base_bin = tag_s2.sop ? LO : max_bin;
      base_pow = tag_s2.sop ? '0 : max_pow;
      take     = tag_s2.in_range && (pow > base_pow);
      best_bin = take ? PTS_W'(tag_s2.bin) : base_bin;
      best_pow = take ? pow : base_pow;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_bin    <= '0;
         max_pow    <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_power <= '0;
      end else begin
         max_bin    <= best_bin;
         max_pow    <= best_pow;
         peak_valid <= tag_s2.report & ~tag_s2.kill;
         if (tag_s2.report & ~tag_s2.kill) begin
            peak_bin   <= best_bin;
            peak_power <= best_pow;
         end
      end
   end

endmodule
